db_key_extract: RTL
===================

Name: db_key_extract

Overview:
- Upstream stage of the key/value DB. Taps the 64-bit receive stream from the 10G MAC and parses Ethernet/IPv4/UDP headers.
- For each valid UDP/IPv4 frame, emits one 96-bit key plus a 4-bit op flag as a single-cycle valid pulse, straight into the DB inputs in_key/in_flag/in_valid.
- Passive tap: no backpressure. Malformed or non-UDP frames are dropped and counted.

Parameters:
- KEY_SIZE, 96, key width; fixed layout {src_ip[31:0], dst_ip[31:0], dst_port[15:0], 16'h0000}.
- MON_PORT, 16'd53, UDP source port that marks a frame as a suspect response (insert op).

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  64  frame data; byte n of beat occupies bits [8n+7:8n], wire byte 0 first.
- s_axis_tkeep  in  8  byte enables.
- s_axis_tvalid  in  1  beat valid; every valid beat is consumed.
- s_axis_tlast  in  1  last beat of frame.
- out_key  out  KEY_SIZE  extracted key, network byte order, MSB first.
- out_flag  out  4  op code: OP_LOOKUP=4'h1, OP_INSERT=4'h2.
- out_valid  out  1  one-cycle pulse qualifying out_key/out_flag.
- stat_pkt  out  32  frames seen (tlast beats).
- stat_key  out  32  keys emitted.
- stat_err  out  32  frames rejected.

Behaviour:
- Reset: all outputs 0, beat counter 0, state IDLE. A reset mid-frame abandons the frame; the next valid beat is treated as beat 0. Garbage frames are rejected by the header checks.
- States:
  - IDLE: waiting for beat 0.
  - HDR: beats 1..4, counter 3 bits.
  - SKIP: discard until tlast.
- Transitions:
  - IDLE -> HDR on a valid beat without tlast.
  - HDR -> SKIP after beat 4 accepted.
  - Any state -> IDLE on a valid beat with tlast.
- Beat map, byte offsets: beat1 [12:13] ethertype, [14] ver/IHL; beat2 [20:21] flags/frag, [23] proto; beat3 [26:29] src_ip, [30:31] dst_ip hi; beat4 [32:33] dst_ip lo, [34:35] src_port, [36:37] dst_port.
- Accept conditions, all required:
  - ethertype == 16'h0800
  - ver/IHL == 8'h45
  - proto == 8'd17
  - MF == 0 and frag offset == 0
  - tkeep == 8'hFF on beats 0-3
  - tkeep[5:0] all set on beat 4
- Check results are accumulated in one sticky "bad" bit per frame.
- Emission: out_valid asserts exactly 1 cycle after the clock edge that accepts beat 4, if bad == 0. out_flag = OP_INSERT if src_port == MON_PORT, else OP_LOOKUP. out_key and out_flag hold their value until the next emission.
- tvalid low cycles (gaps) inside a frame are allowed; state and counter hold.
- tlast on beats 0..3: frame is short. No emission, stat_err += 1.
- tlast on beat 4 with valid checks is a legal minimal frame and emits normally.
- Frames failing any check: stat_err += 1, once per frame, on the cycle the frame's tlast is accepted.
- stat_pkt increments on every accepted tlast beat. stat_key increments with out_valid. All counters wrap 2^32-1 -> 0 and update in the same cycle as their triggering event.
- Max key rate: one key per 5 beats. The DB must accept a pulse every cycle; no FIFO.

Decomposition:
- Shared package db_pkg holds:
  - OP_LOOKUP, OP_INSERT
  - ETH_TYPE_IPV4 = 16'h0800
  - IP_PROTO_UDP = 8'd17
  - the value status codes SUSPECTION = 1, ARREST = 2, FILTERED = 3, EXPIRED = 4
- One natural sub-module, db_stat_cnt: 32-bit wrapping counter with inc input, instantiated 3x. The FSM and field capture stay flat.

Test Plan:
- Minimal UDP frame, 192.168.0.1 -> 10.0.0.2, sport 1234, dport 80, 8 beats -> one out_valid, key 96'hC0A80001_0A000002_0050_0000, flag 4'h1, stat_key=1, stat_pkt=1.
- Same frame with sport 53 -> flag 4'h2. Insert tvalid gaps of 3 cycles between beats -> identical key, out_valid 1 cycle after beat 4 edge.
- Ethertype 16'h86DD, then proto 6, then frag offset 8 -> no out_valid, stat_err=3, stat_pkt=3.
- Frame with tlast on beat 2 followed back-to-back by a good frame -> stat_err=1; good frame emits correctly starting from the next beat.
- Assert rst for one cycle at beat 2 of a good frame, then send a fresh good frame -> all outputs 0 after reset; remnant beats rejected; fresh frame emits its key.
- Force stat_pkt to 32'hFFFFFFFF via 2^32-1 frames (or hierarchical preload), send one frame -> stat_pkt wraps to 0.

Source files
------------

// File: rtl/db_pkg.sv
// Shared definitions for the key/value DB front end: op codes, header
// constants, value status codes and the key payload layout.
package db_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned FLAG_W = 4;

  localparam logic [FLAG_W-1:0] OP_LOOKUP = 4'h1;
  localparam logic [FLAG_W-1:0] OP_INSERT = 4'h2;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;

  // Value status codes stored alongside keys in the DB.
  typedef enum logic [3:0] {
    SUSPECTION = 4'd1,
    ARREST     = 4'd2,
    FILTERED   = 4'd3,
    EXPIRED    = 4'd4
  } db_status_e;

  // Header parser states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SKIP = 2'd2
  } ext_state_e;

  // 96-bit lookup key, MSB first.
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
    logic [15:0] pad;
  } db_key_t;

endpackage

// File: rtl/db_stat_cnt.sv
// Wrapping statistics counter.
//   clk, rst : clock, synchronous active-high reset
//   inc      : add one this cycle
//   count    : current value, wraps from all-ones to zero
module db_stat_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/db_key_extract.sv
// Passive tap on the 64-bit MAC receive stream. Parses Ethernet/IPv4/UDP
// headers over beats 0..4 and emits one key + op flag per good frame.
//   clk, rst          : clock, synchronous active-high reset
//   s_axis_t*         : receive stream (no backpressure, every valid beat taken)
//   out_key/out_flag  : extracted key and op code, held between emissions
//   out_valid         : one-cycle pulse qualifying out_key/out_flag
//   stat_pkt/key/err  : frames seen, keys emitted, frames rejected
module db_key_extract
  import db_pkg::*;
#(
  parameter int unsigned KEY_SIZE = 96,
  parameter logic [15:0] MON_PORT = 16'd53
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [KEEP_W-1:0]   s_axis_tkeep,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic [KEY_SIZE-1:0] out_key,
  output logic [FLAG_W-1:0]   out_flag,
  output logic                out_valid,
  output logic [CNT_W-1:0]    stat_pkt,
  output logic [CNT_W-1:0]    stat_key,
  output logic [CNT_W-1:0]    stat_err
);

  ext_state_e  state, state_nxt;
  logic [2:0]  beat_cnt, beat_cnt_nxt;
  logic        bad, bad_nxt;
  logic [31:0] src_ip_q;
  logic [15:0] dst_hi_q;

  logic        beat_bad_c;
  logic        frame_bad_c;
  logic        emit_c;
  logic        cap_ip_c;
  logic        pkt_inc_c;
  logic        err_inc_c;

  // Byte lanes of the current beat; lane n is wire byte n.
  logic [7:0][7:0] lanes;
  assign lanes = s_axis_tdata;

  logic [15:0] eth_type, frag_word, src_port, dst_port, dst_lo;
  logic [7:0]  ver_ihl, proto;
  assign eth_type  = {lanes[4], lanes[5]};
  assign ver_ihl   = lanes[6];
  assign frag_word = {lanes[4], lanes[5]};
  assign proto     = lanes[7];
  assign dst_lo    = {lanes[0], lanes[1]};
  assign src_port  = {lanes[2], lanes[3]};
  assign dst_port  = {lanes[4], lanes[5]};

  // Per-beat header checks, sticky bad bit, emission and stat triggers.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    bad_nxt      = bad;
    beat_bad_c   = 1'b0;
    frame_bad_c  = bad;
    emit_c       = 1'b0;
    cap_ip_c     = 1'b0;
    pkt_inc_c    = 1'b0;
    err_inc_c    = 1'b0;

    if (s_axis_tvalid) begin
      pkt_inc_c = s_axis_tlast;
      case (state)
        IDLE: begin
          beat_bad_c = (s_axis_tkeep != 8'hFF);
          if (s_axis_tlast) begin
            err_inc_c = 1'b1;
          end else begin
            state_nxt    = HDR;
            beat_cnt_nxt = 3'd1;
            bad_nxt      = beat_bad_c;
          end
        end
        HDR: begin
          case (beat_cnt)
            3'd1: beat_bad_c = (s_axis_tkeep != 8'hFF) || (eth_type != ETH_TYPE_IPV4)
                               || (ver_ihl != IP_VER_IHL);
            // MF flag is bit 13, fragment offset bits 12:0.
            3'd2: beat_bad_c = (s_axis_tkeep != 8'hFF) || frag_word[13]
                               || (frag_word[12:0] != 13'd0) || (proto != IP_PROTO_UDP);
            3'd3: begin
              beat_bad_c = (s_axis_tkeep != 8'hFF);
              cap_ip_c   = 1'b1;
            end
            default: beat_bad_c = (s_axis_tkeep[5:0] != 6'h3F);
          endcase
          frame_bad_c = bad | beat_bad_c;
          bad_nxt     = frame_bad_c;
          if (beat_cnt == 3'd4) begin
            emit_c    = ~frame_bad_c;
            state_nxt = SKIP;
          end else begin
            beat_cnt_nxt = beat_cnt + 3'd1;
          end
          if (s_axis_tlast) begin
            err_inc_c = frame_bad_c | (beat_cnt != 3'd4);
          end
        end
        SKIP: begin
          if (s_axis_tlast) begin
            err_inc_c = bad;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (s_axis_tlast) begin
        state_nxt    = IDLE;
        beat_cnt_nxt = 3'd0;
        bad_nxt      = 1'b0;
      end
    end
  end

  // State, capture and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= 3'd0;
      bad       <= 1'b0;
      src_ip_q  <= '0;
      dst_hi_q  <= '0;
      out_key   <= '0;
      out_flag  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_cnt_nxt;
      bad       <= bad_nxt;
      out_valid <= emit_c;
      if (cap_ip_c) begin
        src_ip_q <= {lanes[2], lanes[3], lanes[4], lanes[5]};
        dst_hi_q <= {lanes[6], lanes[7]};
      end
      if (emit_c) begin
        out_key  <= KEY_SIZE'(db_key_t'{src_ip:   src_ip_q,
                                        dst_ip:   {dst_hi_q, dst_lo},
                                        dst_port: dst_port,
                                        pad:      16'h0000});
        out_flag <= (src_port == MON_PORT) ? OP_INSERT : OP_LOOKUP;
      end
    end
  end

  db_stat_cnt #(.W(CNT_W)) u_stat_pkt (.clk(clk), .rst(rst), .inc(pkt_inc_c), .count(stat_pkt));
  db_stat_cnt #(.W(CNT_W)) u_stat_key (.clk(clk), .rst(rst), .inc(emit_c),    .count(stat_key));
  db_stat_cnt #(.W(CNT_W)) u_stat_err (.clk(clk), .rst(rst), .inc(err_inc_c), .count(stat_err));

endmodule
